// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, instruction-class, ALU opcode and operand-2 encodings
// for the multi-cycle controller and its decoder.
package cpu_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_IR_LOAD, S_EXEC, S_MEM_RD, S_MEM_WR, S_WB, S_TRAP
    } state_t;

    typedef enum logic [1:0] {C_ALU, C_LUI, C_LW, C_SW} instr_class_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDI = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd3;
    localparam logic [3:0] ALU_DIV  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_NOT  = 4'd9;
    localparam logic [3:0] ALU_XOR  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [1:0] OP2_RS2  = 2'b00;
    localparam logic [1:0] OP2_UIMM = 2'b01;
    localparam logic [1:0] OP2_IIMM = 2'b10;
    localparam logic [1:0] OP2_SIMM = 2'b11;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational decode of a 32-bit instruction into class,
// ALU opcode, operand-2 source and a valid flag.
module instr_decode
    import cpu_pkg::*;
#(
    parameter int ALU_OP_W  = 8,
    parameter bit MULDIV_EN = 1'b1,
    parameter bit MEM_EN    = 1'b1
) (
    input  logic [31:0]         instr,
    output instr_class_t        cls,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          op2_dir,
    output logic                valid
);
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [3:0] op;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};
    assign alu_op        = ALU_OP_W'(op);

    always_comb begin
        valid   = 1'b0;
        cls     = C_ALU;
        op      = ALU_ADD;
        op2_dir = OP2_RS2;
        case (opcode)
            OPC_RTYPE: begin
                if (funct7 == 7'b0000000) begin
                    valid = 1'b1;
                    case (funct3)
                        3'b000:  op = ALU_ADD;
                        3'b001:  op = ALU_SLL;
                        3'b101:  op = ALU_SRL;
                        3'b111:  op = ALU_AND;
                        3'b110:  op = ALU_OR;
                        3'b100:  op = ALU_XOR;
                        default: valid = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    valid = 1'b1;
                    op    = ALU_SUB;
                end else if (MULDIV_EN && funct7 == 7'b0000001 && funct3[1:0] == 2'b00) begin
                    valid = 1'b1;
                    op    = funct3[2] ? ALU_DIV : ALU_MUL;
                end
            end
            OPC_OPIMM: begin
                valid   = funct3 == 3'b000;
                op      = ALU_ADDI;
                op2_dir = OP2_IIMM;
            end
            OPC_LUI: begin
                valid   = 1'b1;
                cls     = C_LUI;
                op      = ALU_LUI;
                op2_dir = OP2_UIMM;
            end
            // Loads and stores compute their address as base + immediate.
            OPC_LOAD: begin
                valid   = MEM_EN && funct3 == 3'b010;
                cls     = C_LW;
                op      = ALU_ADDI;
                op2_dir = OP2_IIMM;
            end
            OPC_STORE: begin
                valid   = MEM_EN && funct3 == 3'b010;
                cls     = C_SW;
                op      = ALU_ADDI;
                op2_dir = OP2_SIMM;
            end
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: Moore control FSM sequencing fetch, decode, execute,
// memory access and write-back for a multi-cycle CPU datapath.
module multi_cycle_ctrl
    import cpu_pkg::*;
#(
    parameter int ALU_OP_W  = 8,
    parameter bit MULDIV_EN = 1'b1,
    parameter bit MEM_EN    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                ram_ready,
    input  logic                alu_busy,
    output logic                ram_cs,
    output logic                ram_oe,
    output logic                ram_we,
    output logic                addr_sel,
    output logic                pc_en,
    output logic                pc_in_dir,
    output logic                pc_sign,
    output logic                ir_en,
    output logic                reg_en,
    output logic                reg_we,
    output logic                reg_in_dir,
    output logic                alu_en,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          op2_dir,
    output logic                illegal
);
    state_t              state, state_nx;
    instr_class_t        dec_cls, cls_q;
    logic [ALU_OP_W-1:0] dec_op, op_q;
    logic [1:0]          dec_o2, o2_q;
    logic                dec_valid;

    instr_decode #(
        .ALU_OP_W  (ALU_OP_W),
        .MULDIV_EN (MULDIV_EN),
        .MEM_EN    (MEM_EN)
    ) u_decode (
        .instr   (instr),
        .cls     (dec_cls),
        .alu_op  (dec_op),
        .op2_dir (dec_o2),
        .valid   (dec_valid)
    );

    // Decode is captured at the end of IR_LOAD so later states never look at instr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cls_q <= C_ALU;
            op_q  <= '0;
            o2_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IR_LOAD) begin
                cls_q <= dec_cls;
                op_q  <= dec_op;
                o2_q  <= dec_o2;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    state_nx = S_FETCH;
            S_FETCH:   state_nx = ram_ready ? S_IR_LOAD : S_FETCH;
            S_IR_LOAD: state_nx = dec_valid ? S_EXEC : S_TRAP;
            S_EXEC:    state_nx = alu_busy ? S_EXEC :
                                  cls_q == C_LW ? S_MEM_RD :
                                  cls_q == C_SW ? S_MEM_WR : S_WB;
            S_MEM_RD:  state_nx = ram_ready ? S_WB : S_MEM_RD;
            S_MEM_WR:  state_nx = ram_ready ? S_FETCH : S_MEM_WR;
            S_WB:      state_nx = S_FETCH;
            default:   state_nx = S_TRAP;
        endcase
    end

    assign ram_cs     = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    assign ram_oe     = state inside {S_FETCH, S_MEM_RD};
    assign ram_we     = state == S_MEM_WR;
    assign addr_sel   = state inside {S_MEM_RD, S_MEM_WR};
    assign pc_en      = state == S_IR_LOAD;
    assign pc_in_dir  = 1'b0;
    assign pc_sign    = 1'b0;
    assign ir_en      = state == S_IR_LOAD;
    assign reg_en     = state == S_WB;
    assign reg_we     = state == S_WB;
    assign reg_in_dir = state == S_WB && cls_q == C_LW;
    assign alu_en     = state == S_EXEC;
    assign alu_op     = alu_en ? op_q : '0;
    assign op2_dir    = alu_en ? o2_q : '0;
    assign illegal    = state == S_TRAP;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed and randomized checks of the controller
// against a phase-level model of each instruction's cycle sequence.
module tb_multi_cycle_ctrl;
    logic        clk = 1'b0, rst = 1'b1, ram_ready = 1'b0, alu_busy = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        ram_cs, ram_oe, ram_we, addr_sel, pc_en, pc_in_dir, pc_sign, ir_en;
    logic        reg_en, reg_we, reg_in_dir, alu_en, illegal;
    logic [7:0]  alu_op;
    logic [1:0]  op2_dir;
    logic        d2_cs, d2_oe, d2_we, d2_as, d2_pc, d2_pdir, d2_psign, d2_ir;
    logic        d2_ren, d2_rwe, d2_rdir, d2_aen, d2_ill;
    logic [7:0]  d2_op;
    logic [1:0]  d2_o2;
    logic [22:0] obs;
    int          vectors = 0, errors = 0;

    typedef struct { bit ok; int kind; int op; int o2; } dec_t;
    typedef struct { logic [22:0] exp; logic rr; logic ab; logic [31:0] ins; } cyc_t;
    cyc_t sched[$];

    localparam logic [22:0] CS = 23'd1 << 22, OE = 23'd1 << 21, WE = 23'd1 << 20, AS = 23'd1 << 19;
    localparam logic [22:0] PC = 23'd1 << 18, IR = 23'd1 << 15, REN = 23'd1 << 14, RWE = 23'd1 << 13;
    localparam logic [22:0] RDIR = 23'd1 << 12, AEN = 23'd1 << 11, ILL = 23'd1;

    multi_cycle_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .ram_ready(ram_ready), .alu_busy(alu_busy),
        .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we), .addr_sel(addr_sel), .pc_en(pc_en),
        .pc_in_dir(pc_in_dir), .pc_sign(pc_sign), .ir_en(ir_en), .reg_en(reg_en), .reg_we(reg_we),
        .reg_in_dir(reg_in_dir), .alu_en(alu_en), .alu_op(alu_op), .op2_dir(op2_dir), .illegal(illegal)
    );

    multi_cycle_ctrl #(.MULDIV_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .instr(instr), .ram_ready(ram_ready), .alu_busy(alu_busy),
        .ram_cs(d2_cs), .ram_oe(d2_oe), .ram_we(d2_we), .addr_sel(d2_as), .pc_en(d2_pc),
        .pc_in_dir(d2_pdir), .pc_sign(d2_psign), .ir_en(d2_ir), .reg_en(d2_ren), .reg_we(d2_rwe),
        .reg_in_dir(d2_rdir), .alu_en(d2_aen), .alu_op(d2_op), .op2_dir(d2_o2), .illegal(d2_ill)
    );

    assign obs = {ram_cs, ram_oe, ram_we, addr_sel, pc_en, pc_in_dir, pc_sign, ir_en,
                  reg_en, reg_we, reg_in_dir, alu_en, alu_op, op2_dir, illegal};

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // kind: 0 = ALU op, 1 = LUI, 2 = LW, 3 = SW
    function automatic dec_t ref_dec(input logic [31:0] i, input bit md, input bit mem);
        dec_t d;
        int rf3[6] = '{0, 1, 5, 7, 6, 4};
        int rop[6] = '{0, 5, 6, 7, 8, 10};
        int opc = int'(i[6:0]), f3 = int'(i[14:12]), f7 = int'(i[31:25]);
        d = '{0, 0, 0, 0};
        if (opc == 'h33 && f7 == 0)
            for (int k = 0; k < 6; k++) if (f3 == rf3[k]) d = '{1, 0, rop[k], 0};
        if (opc == 'h33 && f7 == 'h20 && f3 == 0) d = '{1, 0, 2, 0};
        if (md && opc == 'h33 && f7 == 1 && (f3 == 0 || f3 == 4)) d = '{1, 0, (f3 == 0) ? 3 : 4, 0};
        if (opc == 'h13 && f3 == 0) d = '{1, 0, 1, 2};
        if (opc == 'h37) d = '{1, 1, 11, 1};
        if (mem && opc == 'h03 && f3 == 2) d = '{1, 2, 1, 2};
        if (mem && opc == 'h23 && f3 == 2) d = '{1, 3, 1, 3};
        return d;
    endfunction

    function automatic void add(input logic [22:0] e, input logic rr, input logic ab, input logic [31:0] ins);
        cyc_t c;
        c.exp = e; c.rr = rr; c.ab = ab; c.ins = ins;
        sched.push_back(c);
    endfunction

    // Expected per-cycle outputs plus the inputs to drive in each cycle; instr is
    // only held stable while it may legally be sampled, random otherwise.
    function automatic void push_instr(input logic [31:0] ins, input int fw, input int ew, input int mw, input bit md);
        dec_t d = ref_dec(ins, md, 1'b1);
        logic [22:0] ex = AEN | {12'b0, 8'(d.op), 2'(d.o2), 1'b0};
        for (int k = 0; k <= fw; k++) add(CS | OE, k == fw, rb(), $urandom);
        add(PC | IR, rb(), rb(), ins);
        if (!d.ok) begin
            for (int k = 0; k < 3; k++) add(ILL, rb(), rb(), $urandom);
            return;
        end
        for (int k = 0; k <= ew; k++) add(ex, rb(), k < ew, ins);
        if (d.kind == 2) begin
            for (int k = 0; k <= mw; k++) add(CS | OE | AS, k == mw, rb(), $urandom);
            add(REN | RWE | RDIR, rb(), rb(), $urandom);
        end else if (d.kind == 3) begin
            for (int k = 0; k <= mw; k++) add(CS | WE | AS, k == mw, rb(), $urandom);
        end else begin
            add(REN | RWE, rb(), rb(), $urandom);
        end
    endfunction

    task automatic do_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        add('0, rb(), rb(), $urandom);
    endtask

    task automatic test_reset();
        cyc_t c;
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== '0) begin errors++; $display("FAIL reset_hold: got %h want %h", obs, 23'h0); end
        @(negedge clk);
        rst = 1'b0;
        add('0, 1'b0, 1'b0, 32'h0);
        add(CS | OE, 1'b0, 1'b0, 32'h0);
        add(CS | OE, 1'b0, 1'b0, 32'h0);
        while (sched.size() > 0) begin
            c = sched.pop_front();
            vectors++;
            if (obs !== c.exp) begin errors++; $display("FAIL reset_seq: got %h want %h", obs, c.exp); end
            ram_ready = c.rr; alu_busy = c.ab; instr = c.ins;
            @(negedge clk);
        end
    endtask

    task automatic test_directed(input string name, input logic [31:0] ins, input int fw, input int ew, input int mw);
        cyc_t c;
        do_reset();
        push_instr(ins, fw, ew, mw, 1'b1);
        while (sched.size() > 0) begin
            c = sched.pop_front();
            vectors++;
            if (obs !== c.exp) begin errors++; $display("FAIL %s: got %h want %h", name, obs, c.exp); end
            ram_ready = c.rr; alu_busy = c.ab; instr = c.ins;
            @(negedge clk);
        end
    endtask

    task automatic test_trap();
        cyc_t c;
        do_reset();
        push_instr(32'hFFFFFFFF, 1, 0, 0, 1'b1);
        while (sched.size() > 0) begin
            c = sched.pop_front();
            vectors++;
            if (obs !== c.exp) begin errors++; $display("FAIL trap_seq: got %h want %h", obs, c.exp); end
            ram_ready = c.rr; alu_busy = c.ab; instr = c.ins;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (illegal !== 1'b0 || obs !== '0) begin errors++; $display("FAIL trap_clear: got %h want %h", obs, 23'h0); end
        @(negedge clk);
        rst = 1'b0;
        add('0, 1'b0, 1'b0, 32'h0);
        add(CS | OE, 1'b0, 1'b0, 32'h0);
        while (sched.size() > 0) begin
            c = sched.pop_front();
            vectors++;
            if (obs !== c.exp) begin errors++; $display("FAIL trap_restart: got %h want %h", obs, c.exp); end
            ram_ready = c.rr; alu_busy = c.ab; instr = c.ins;
            @(negedge clk);
        end
    endtask

    task automatic test_rst_in_fetch();
        cyc_t c;
        do_reset();
        for (int k = 0; k < 3; k++) add(CS | OE, 1'b0, rb(), $urandom);
        while (sched.size() > 0) begin
            c = sched.pop_front();
            vectors++;
            if (obs !== c.exp) begin errors++; $display("FAIL fetch_wait: got %h want %h", obs, c.exp); end
            ram_ready = c.rr; alu_busy = c.ab; instr = c.ins;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== '0) begin errors++; $display("FAIL async_rst_fetch: got %h want %h", obs, 23'h0); end
        @(negedge clk);
        rst = 1'b0;
        ram_ready = 1'b0;
    endtask

    task automatic test_muldiv_off();
        cyc_t c;
        do_reset();
        push_instr(32'h0220C1B3, 0, 1, 0, 1'b1);
        while (sched.size() > 0) begin
            c = sched.pop_front();
            vectors++;
            if (obs !== c.exp) begin errors++; $display("FAIL div_enabled: got %h want %h", obs, c.exp); end
            ram_ready = c.rr; alu_busy = c.ab; instr = c.ins;
            @(negedge clk);
        end
        vectors++;
        if ({d2_ill, d2_cs, d2_aen} !== 3'b100) begin
            errors++; $display("FAIL div_disabled_trap: got %b want %b", {d2_ill, d2_cs, d2_aen}, 3'b100);
        end
    endtask

    task automatic test_back_to_back();
        cyc_t c;
        logic [31:0] ins;
        dec_t d;
        int sel;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 5))
                0: begin
                    ins[6:0] = 7'h33;
                    sel = $urandom_range(0, 3);
                    ins[31:25] = (sel == 1) ? 7'h20 : (sel == 2) ? 7'h01 : 7'h00;
                end
                1: begin ins[6:0] = 7'h13; if ($urandom_range(0, 3) != 0) ins[14:12] = 3'b000; end
                2: ins[6:0] = 7'h37;
                3: begin ins[6:0] = 7'h03; if ($urandom_range(0, 3) != 0) ins[14:12] = 3'b010; end
                4: begin ins[6:0] = 7'h23; if ($urandom_range(0, 3) != 0) ins[14:12] = 3'b010; end
                default: ;
            endcase
            d = ref_dec(ins, 1'b1, 1'b1);
            push_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
            while (sched.size() > 0) begin
                c = sched.pop_front();
                vectors++;
                if (obs !== c.exp) begin errors++; $display("FAIL b2b instr %h: got %h want %h", ins, obs, c.exp); end
                ram_ready = c.rr; alu_busy = c.ab; instr = c.ins;
                @(negedge clk);
            end
            if (!d.ok) do_reset();
        end
        sched.delete();
    endtask

    initial begin
        test_reset();
        test_directed("addi", 32'h00500093, 0, 0, 0);
        test_directed("mul_busy", 32'h022081B3, 1, 3, 0);
        test_directed("lw_wait", 32'h0000A103, 0, 0, 2);
        test_directed("sw", 32'h0020A223, 1, 0, 1);
        test_directed("lui", 32'h123450B7, 0, 1, 0);
        test_directed("sub", 32'h402081B3, 2, 0, 0);
        test_trap();
        test_rst_in_fetch();
        test_muldiv_off();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 8: width of alu_op.
REQ-002 SHALL have parameter MULDIV_EN, default 1: 1 = decode MUL/DIV; 0 = MUL/DIV treated as illegal.
REQ-003 SHALL have parameter MEM_EN, default 1: 1 = decode LW/SW; 0 = LW/SW treated as illegal.
REQ-004 One clock, clk; reset is asynchronous and active-high, rst.
REQ-005 clk  input  1  system clock, all state changes on rising edge.
REQ-006 rst  input  1  async active-high reset.
REQ-007 instr  input  32  IR contents, valid from the cycle after ir_en.
REQ-008 ram_ready  input  1  RAM access completes in the current cycle.
REQ-009 alu_busy  input  1  ALU still computing (multi-cycle MUL/DIV).
REQ-010 ram_cs, ram_oe, ram_we  output  1 each  RAM chip select, read enable, write enable.
REQ-011 addr_sel  output  1  RAM address source: 0 = PC, 1 = ALU result.
REQ-012 pc_en, pc_in_dir, pc_sign  output  1 each  PC increment enable, load direction, sign; the last two are always 0 in this block.
REQ-013 ir_en  output  1  IR load.
REQ-014 reg_en, reg_we, reg_in_dir  output  1 each  register-file enable, write, write-data source (0 = ALU, 1 = RAM).
REQ-015 alu_en  output  1  ALU enable.
REQ-016 alu_op  output  ALU_OP_W  ALU operation code.
REQ-017 op2_dir  output  2  ALU operand-2 source: 00 = rs2, 01 = U-imm, 10 = I-imm, 11 = S-imm.
REQ-018 illegal  output  1  sticky undecodable-instruction flag.

Function
REQ-019 States SHALL be IDLE, FETCH, IR_LOAD, EXEC, MEM_RD, MEM_WR, WB and TRAP.
REQ-020 Outputs SHALL be a pure function of the registered state (Moore); every output not listed for a state SHALL be 0.
REQ-021 IDLE: no outputs; IDLE SHALL go to FETCH on the next edge.
REQ-022 FETCH: ram_cs=1, ram_oe=1, addr_sel=0; hold while ram_ready=0, else go to IR_LOAD.
REQ-023 IR_LOAD: ir_en=1, pc_en=1 for exactly one cycle; go to EXEC, or to TRAP if instr does not decode.
REQ-024 R-type decode (opcode 0110011): funct7 0000000 with funct3 000/001/101/111/110/100 selects ADD/SLL/SRL/AND/OR/XOR.
REQ-025 R-type decode: funct7 0100000 with funct3 000 selects SUB.
REQ-026 R-type decode: funct7 0000001 with funct3 000/100 selects MUL/DIV.
REQ-027 Other decodes: ADDI = opcode 0010011 with funct3 000; LUI = opcode 0110111; LW = opcode 0000011 with funct3 010; SW = opcode 0100011 with funct3 010.
REQ-028 alu_op codes SHALL be ADD=0, ADDI=1, SUB=2, MUL=3, DIV=4, SLL=5, SRL=6, AND=7, OR=8, NOT=9, XOR=10, LUI=11, zero-extended to ALU_OP_W.
REQ-029 EXEC: alu_en=1 with alu_op/op2_dir per the decoded instruction; EXEC SHALL hold while alu_busy=1.
REQ-030 EXEC exit: LW goes to MEM_RD, SW goes to MEM_WR, all others go to WB.
REQ-031 EXEC operand selection: LW and SW use alu_op=ADDI, with op2_dir 10 for LW and 11 for SW; LUI uses op2_dir 01.
REQ-032 MEM_RD: ram_cs=1, ram_oe=1, addr_sel=1; hold while ram_ready=0, else go to WB.
REQ-033 MEM_WR: ram_cs=1, ram_we=1, addr_sel=1; hold while ram_ready=0, else go to FETCH.
REQ-034 WB: reg_en=1, reg_we=1, reg_in_dir=1 for LW (else 0); one cycle, then go to FETCH.
REQ-035 TRAP: illegal=1, all other outputs 0; TRAP SHALL stay in TRAP until rst.
REQ-036 ram_we and ram_oe SHALL never both be 1.
REQ-037 ir_en and reg_we SHALL never both be 1.
REQ-038 Latency with zero wait states: ALU ops and LUI take 4 cycles (FETCH to WB), LW takes 5, SW takes 4.
REQ-039 Each wait cycle on ram_ready or alu_busy SHALL add exactly one cycle to the instruction.
REQ-040 instr SHALL be sampled only in IR_LOAD and EXEC; changes to instr in any other state SHALL have no effect.

Reset
REQ-041 rst=1 SHALL force state to IDLE and every output to 0 asynchronously, including when asserted mid-wait in FETCH or MEM_*.
REQ-042 rst=1 SHALL clear illegal.
REQ-043 After rst deasserts, the first rising edge SHALL move IDLE to FETCH.

Structure
REQ-044 The ALU opcode constants, the op2_dir encodings and the state encoding SHALL live in a shared package, cpu_pkg.
REQ-045 Instruction decode SHALL be a combinational sub-module, instr_decode, producing the instruction class, alu_op, op2_dir and a valid flag.

Verification
REQ-046 Bench SHALL cover ADDI x1,x0,5 (0x00500093), ram_ready tied 1 -> 4-cycle sequence FETCH, IR_LOAD, EXEC (alu_op=1, op2_dir=10), WB (reg_we=1, reg_in_dir=0).
REQ-047 Bench SHALL cover MUL (0x022081B3) with alu_busy held high 3 cycles -> EXEC lasts exactly 4 cycles, then WB, alu_op=3.
REQ-048 Bench SHALL cover LW (0x0000A103) with ram_ready low 2 cycles in MEM_RD -> addr_sel=1 throughout MEM_RD, then WB with reg_in_dir=1; total 7 cycles.
REQ-049 Bench SHALL cover instr=0xFFFFFFFF -> TRAP with illegal=1 from the cycle after IR_LOAD; then rst pulse -> illegal=0 and state=IDLE.
REQ-050 Bench SHALL cover rst asserted in FETCH while ram_ready=0 -> all outputs 0 immediately, without waiting for a clock edge.
REQ-051 Bench SHALL cover MULDIV_EN=0 with DIV (0x0220C1B3) -> TRAP.
